ab_conditioner: RTL
===================

AB_CONDITIONER -- requirements
Module: ab_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required before an output changes (legal range 1..255).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset; synchronous and active-high.
REQ-004 Port: A_RAW  input  1  asynchronous raw level (switch/pin) for channel A.
REQ-005 Port: B_RAW  input  1  asynchronous raw level for channel B.
REQ-006 Port: A  output  1  debounced, synchronized level; drives A of the downstream two-flop sequential stage.
REQ-007 Port: B  output  1  debounced, synchronized level; drives B of the downstream stage.
REQ-008 Port: A_RISE  output  1  one-cycle pulse when A goes 0->1.
REQ-009 Port: B_RISE  output  1  one-cycle pulse when B goes 0->1.
REQ-010 Port: CHG  output  1  one-cycle pulse when A or B changes in that cycle.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL run an independent 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-013 STABLE_LO -> PEND_HI when sync2=1; STABLE_HI -> PEND_LO when sync2=0; counter loads 1 on entry.
REQ-014 In PEND_x, counter increments while sync2 holds the new level; when count reaches DEBOUNCE_CYCLES, the FSM enters the opposite STABLE state and the output toggles on that edge.
REQ-015 In PEND_x, a sync2 return to the old level before count reaches DEBOUNCE_CYCLES SHALL return the FSM to the prior STABLE state, clear the counter, and leave the output unchanged.
REQ-016 With DEBOUNCE_CYCLES=1, PEND_x SHALL be skipped: the output toggles on the first edge at which sync2 differs from the output.
REQ-017 Latency: first rising edge sampling the new raw level = edge 1; the output changes on edge DEBOUNCE_CYCLES+2 if the raw level holds.
REQ-018 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap; it holds at or below DEBOUNCE_CYCLES.
REQ-019 A_RISE/B_RISE SHALL assert for exactly the cycle following the edge where A/B went 0->1; no pulse on 1->0.
REQ-020 CHG SHALL assert for one cycle whenever A or B toggled on the preceding edge; simultaneous A and B changes produce one single-cycle CHG.
REQ-021 Channels SHALL be fully independent; activity on one never alters the timing of the other.
REQ-022 Outputs A, B, A_RISE, B_RISE, CHG SHALL be registered (no combinational path from raw inputs).

Reset
REQ-023 RST=1 at a rising edge SHALL clear sync flops, counters, and outputs A, B, A_RISE, B_RISE, CHG to 0, and set both FSMs to STABLE_LO.
REQ-024 Reset asserted mid-PEND SHALL discard the pending count; no pulse is emitted on reset or on the first cycle after release.
REQ-025 A raw input held at 1 through reset release SHALL be debounced normally: output rises DEBOUNCE_CYCLES+2 edges after release, with a rise pulse.

Structure
REQ-026 Package ab_cond_pkg SHALL hold the channel state enum and the default DEBOUNCE_CYCLES constant.
REQ-027 A sub-module debounce_ch (synchronizer + FSM + counter + rise detect) SHALL be instantiated twice; ab_conditioner adds only the CHG logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 A_RAW 0->1 held -> A=1 at edge 6, A_RISE=1 for one cycle after edge 6, CHG=1 in that same cycle.
REQ-029 A_RAW high for 3 cycles then low -> A stays 0, no A_RISE, no CHG.
REQ-030 A_RAW and B_RAW rise on the same edge -> A and B both rise at edge 6, CHG pulses once, A_RISE and B_RISE both pulse.
REQ-031 A=1 stable, A_RAW falls and is held -> A=0 at edge 6, no A_RISE, CHG pulses once.
REQ-032 RST asserted at PEND_HI count 3 -> all outputs 0, A_RAW held high thereafter -> A rises 6 edges after release.
REQ-033 DEBOUNCE_CYCLES=1, A_RAW toggles every 4 cycles -> A follows with a 3-edge delay, one A_RISE per rise.

Source files
------------

// File: rtl/ab_cond_pkg.sv
// Shared types and defaults for the two-channel input conditioner.
package ab_cond_pkg;

    // Per-channel debounce state: a stable level, or a pending move towards the other level.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } ch_state_t;

    // Consecutive stable synchronized samples needed before an output moves.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_ch.sv
// One conditioned channel: two-flop synchronizer, debounce FSM with a saturating
// stability counter, registered level and a registered 0->1 pulse. The toggle
// output flags that level changes on the coming edge, so the parent can register
// a change pulse that lines up with the level and rise outputs.
module debounce_ch
    import ab_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    ch_state_t     state;
    ch_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          level_n;
    logic          rise_n;

    // Synchronizer, FSM state, counter and outputs, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values;
        // blocking here would let sync2 see this edge's sync1 and collapse the synchronizer.
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            level <= level_n;
            rise  <= rise_n;
        end
    end

    // Next-state logic: count consecutive new-level samples, commit at DEBOUNCE_CYCLES.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_n = state;
        cnt_n   = cnt;
        level_n = level;
        rise_n  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = STABLE_HI;
                        level_n = 1'b1;
                        rise_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = PEND_HI;
                        cnt_n   = CW'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!sync2) begin
                    state_n = STABLE_LO;
                    cnt_n   = '0;
                end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
                    state_n = STABLE_HI;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = STABLE_LO;
                        level_n = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        state_n = PEND_LO;
                        cnt_n   = CW'(1);
                    end
                end
            end
            PEND_LO: begin
                if (sync2) begin
                    state_n = STABLE_HI;
                    cnt_n   = '0;
                end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
                    state_n = STABLE_LO;
                    level_n = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = STABLE_LO;
                cnt_n   = '0;
            end
        endcase
    end

    assign toggle = (level_n != level);

endmodule

// File: rtl/ab_conditioner.sv
// Two independent debounced channels feeding a downstream A/B stage, plus a
// registered one-cycle pulse whenever either conditioned level changes.
module ab_conditioner
    import ab_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic A_RAW,
    input  logic B_RAW,
    output logic A,
    output logic B,
    output logic A_RISE,
    output logic B_RISE,
    output logic CHG
);

    logic a_toggle;
    logic b_toggle;

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
        .clk    (CLK),
        .rst    (RST),
        .raw    (A_RAW),
        .level  (A),
        .rise   (A_RISE),
        .toggle (a_toggle)
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
        .clk    (CLK),
        .rst    (RST),
        .raw    (B_RAW),
        .level  (B),
        .rise   (B_RISE),
        .toggle (b_toggle)
    );

    // Change pulse registered on the same edge the levels move; simultaneous changes merge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CHG <= 1'b0;
        end else begin
            CHG <= a_toggle | b_toggle;
        end
    end

endmodule
